// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default baud divisor and widths.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam int BAUD_DIV_115200 = 434;
  localparam int DATA_BITS       = 8;
  localparam int CNT_W           = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last cycle of each bit.
// The receiver reuses this counter, sampling at the mid-bit count.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_115200
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clear,
  output logic bit_end
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == LAST_CNT);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)               cnt <= '0;
    else if (clear || bit_end) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter, LSB first, idle-high registered line output.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_module #(
  parameter int BAUD_DIV  = uart_pkg::BAUD_DIV_115200,
  parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 TX_En_Sig,
  input  logic [DATA_BITS-1:0] TX_Data,
  output logic                 TX_Busy,
  output logic                 TX_Done_Sig,
  output logic                 TX_Pin_Out
);

  import uart_pkg::*;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e          state, state_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [2:0]           bit_idx, bit_idx_d;
  logic                 pin_d;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  // Counter is held at zero while idle so each frame starts on a fresh bit period.
  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clear   (state == IDLE),
    .bit_end (bit_end)
  );

  assign TX_Busy = (state != IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state;
    shift_d     = shift;
    bit_idx_d   = bit_idx;
    TX_Done_Sig = 1'b0;
    case (state)
      IDLE: if (TX_En_Sig) begin
        shift_d = TX_Data;
        state_d = START;
      end
      START: if (bit_end) begin
        bit_idx_d = '0;
        state_d   = DATA;
      end
      DATA: if (bit_end) begin
        shift_d   = shift >> 1;
        bit_idx_d = bit_idx + 1'b1;
        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) begin
        TX_Done_Sig = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so the pin flop changes with the state.
  always_comb begin
    pin_d = 1'b1;
    case (state_d)
      START:   pin_d = 1'b0;
      DATA:    pin_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  pin_d = parity_q;
`endif
      default: pin_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      TX_Pin_Out <= 1'b1;
    end else begin
      state      <= state_d;
      shift      <= shift_d;
      bit_idx    <= bit_idx_d;
      TX_Pin_Out <= pin_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the byte as accepted; the shift register is consumed during DATA.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                         parity_q <= 1'b0;
    else if (state == IDLE && TX_En_Sig) parity_q <= ^TX_Data;
  end
`endif

endmodule

// File: tb/tb_uart_tx_module.sv
// Self-checking bench for uart_tx_module at BAUD_DIV=4 against a bit-list frame model.
// Honours UART_TX_PARITY_EN when computing the expected frame.
module tb_uart_tx_module;

  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       CLK = 1'b0;
  logic       RSTn = 1'b1;
  logic       TX_En_Sig = 1'b0;
  logic [7:0] TX_Data = 8'h00;
  logic       TX_Busy;
  logic       TX_Done_Sig;
  logic       TX_Pin_Out;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_module #(.BAUD_DIV(BD), .DATA_BITS(8)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .TX_En_Sig   (TX_En_Sig),
    .TX_Data     (TX_Data),
    .TX_Busy     (TX_Busy),
    .TX_Done_Sig (TX_Done_Sig),
    .TX_Pin_Out  (TX_Pin_Out)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after the accept edge; checks every cycle of the frame plus the idle cycle after it.
  // poke: cycle at which a stray request is raised for one cycle; abort: cycle at which reset hits.
  task automatic check_frame(input logic [7:0] d, input int poke, input int abort);
    logic exp_bits[$];
    logic exp_pin;
    int   total;
    exp_bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) exp_bits.push_back(d[k]);
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(^d);
`endif
    exp_bits.push_back(1'b1);
    total = exp_bits.size() * BD;
    for (int i = 1; i <= total; i++) begin
      @(negedge CLK);
      if (i == abort) begin
        RSTn = 1'b0;
        #1;
        for (int r = 0; r < 3; r++) begin
          n_checks += 3;
          if (TX_Pin_Out !== 1'b1) begin n_fail++; $display("FAIL abort_pin d=%h r=%0d got=%b want=1", d, r, TX_Pin_Out); end
          if (TX_Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy d=%h r=%0d got=%b want=0", d, r, TX_Busy); end
          if (TX_Done_Sig !== 1'b0) begin n_fail++; $display("FAIL abort_done d=%h r=%0d got=%b want=0", d, r, TX_Done_Sig); end
          @(negedge CLK);
        end
        RSTn = 1'b1;
        return;
      end
      exp_pin = exp_bits[(i - 1) / BD];
      n_checks += 3;
      if (TX_Pin_Out !== exp_pin) begin n_fail++; $display("FAIL pin d=%h cyc=%0d got=%b want=%b", d, i, TX_Pin_Out, exp_pin); end
      if (TX_Busy !== 1'b1) begin n_fail++; $display("FAIL busy d=%h cyc=%0d got=%b want=1", d, i, TX_Busy); end
      if (TX_Done_Sig !== (i == total)) begin n_fail++; $display("FAIL done d=%h cyc=%0d got=%b want=%b", d, i, TX_Done_Sig, (i == total)); end
      if (i == poke) begin TX_En_Sig = 1'b1; TX_Data = 8'h00; end
      if (i == poke + 1) TX_En_Sig = 1'b0;
    end
    @(negedge CLK);
    n_checks += 3;
    if (TX_Pin_Out !== 1'b1) begin n_fail++; $display("FAIL idle_pin d=%h got=%b want=1", d, TX_Pin_Out); end
    if (TX_Busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy d=%h got=%b want=0", d, TX_Busy); end
    if (TX_Done_Sig !== 1'b0) begin n_fail++; $display("FAIL idle_done d=%h got=%b want=0", d, TX_Done_Sig); end
  endtask

  task automatic send(input logic [7:0] d, input bit hold, input int poke, input int abort);
    @(negedge CLK);
    n_checks++;
    if (TX_Busy !== 1'b0) begin n_fail++; $display("FAIL pre_idle d=%h got=%b want=0", d, TX_Busy); end
    TX_En_Sig = 1'b1;
    TX_Data   = d;
    @(posedge CLK);
    #1;
    if (!hold) TX_En_Sig = 1'b0;
    check_frame(d, poke, abort);
  endtask

  task automatic test_reset;
    TX_En_Sig = 1'b1;
    TX_Data   = 8'h55;
    #1 RSTn = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge CLK);
      n_checks += 3;
      if (TX_Pin_Out !== 1'b1) begin n_fail++; $display("FAIL rst_pin r=%0d got=%b want=1", r, TX_Pin_Out); end
      if (TX_Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy r=%0d got=%b want=0", r, TX_Busy); end
      if (TX_Done_Sig !== 1'b0) begin n_fail++; $display("FAIL rst_done r=%0d got=%b want=0", r, TX_Done_Sig); end
    end
    RSTn = 1'b1;
    @(posedge CLK);
    #1;
    TX_En_Sig = 1'b0;
    check_frame(8'h55, -10, -10);
  endtask

  task automatic test_send_55;
    send(8'h55, 1'b0, -10, -10);
  endtask

  task automatic test_data_change;
    @(negedge CLK);
    TX_En_Sig = 1'b1;
    TX_Data   = 8'hA3;
    @(posedge CLK);
    #1;
    TX_En_Sig = 1'b0;
    TX_Data   = 8'h00;
    check_frame(8'hA3, -10, -10);
  endtask

  task automatic test_back_to_back;
    send(8'h0F, 1'b1, -10, -10);
    @(posedge CLK);
    #1;
    TX_En_Sig = 1'b0;
    check_frame(8'h0F, -10, -10);
  endtask

  task automatic test_ignore_busy;
    send(8'h81, 1'b0, 4 * BD + 2, -10);
    repeat (2) begin
      @(negedge CLK);
      n_checks++;
      if (TX_Busy !== 1'b0) begin n_fail++; $display("FAIL no_queue busy got=%b want=0", TX_Busy); end
    end
  endtask

  task automatic test_reset_mid_frame;
    send(8'hFF, 1'b0, -10, 4 * BD + 1);
    send(8'h3C, 1'b0, -10, -10);
  endtask

  task automatic test_random;
    logic [7:0] d;
    repeat (8) begin
      d = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      send(d, 1'b0, -10, -10);
    end
  endtask

  initial begin
    test_reset;
    test_send_55;
    test_data_change;
    test_back_to_back;
    test_ignore_busy;
    test_reset_mid_frame;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
